// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot-time instruction-memory loader.
// Keeps the CPU in reset and takes a byte stream: a 16-bit big-endian word
// count N, then N big-endian 32-bit words. Each word is written to
// consecutive instruction-memory word addresses starting at 0, and the CPU
// is released once the image is complete. A header with N larger than the
// memory, or an idle gap in the stream, ends the load in ERROR.
//
// Handshake: a byte moves on any rising clk edge where rx_valid && rx_ready.
// rx_ready is registered and is high only while the loader waits for header
// or data bytes, so it is already low in the WRITE cycle and the source has
// to hold the byte until it is accepted.
module imem_boot_loader #(
  parameter int          ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_DONE   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  // A count equal to the capacity is legal; only a larger count is rejected.
  localparam logic [16:0]           CAPACITY = 17'(1) << ADDR_WIDTH;
  localparam logic [31:0]           TO_LAST  = 32'(TIMEOUT_CYCLES) - 32'd1;
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);

  state_t                state, state_n;
  logic [15:0]           words_left;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [1:0]            byte_cnt;
  logic [23:0]           shift;
  logic [31:0]           timer;
  logic                  accept;
  logic                  waiting;
  logic                  timeout_hit;
  logic [15:0]           hdr_n;

  assign dbg_state   = state;
  assign accept      = rx_valid && rx_ready;
  assign waiting     = (state == S_HDR_HI) || (state == S_HDR_LO) || (state == S_DATA);
  assign hdr_n       = {words_left[15:8], rx_data};
  // The timer holds the idle cycles already counted; the cycle that would
  // bring it to TIMEOUT_CYCLES aborts the load instead.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && waiting && !accept && (timer == TO_LAST);

  // Next-state decision; an accepted byte always has priority over timeout and start.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_n = S_HDR_HI;
      end
      S_HDR_HI: begin
        if (accept)           state_n = S_HDR_LO;
        else if (timeout_hit) state_n = S_ERROR;
      end
      S_HDR_LO: begin
        if (accept) begin
          if (hdr_n == 16'd0)                 state_n = S_DONE;
          else if ({1'b0, hdr_n} > CAPACITY)  state_n = S_ERROR;
          else                                state_n = S_DATA;
        end else if (timeout_hit) begin
          state_n = S_ERROR;
        end
      end
      S_DATA: begin
        if (accept && (byte_cnt == 2'd3)) state_n = S_WRITE;
        else if (timeout_hit)             state_n = S_ERROR;
      end
      S_WRITE: begin
        state_n = (words_left == 16'd1) ? S_DONE : S_DATA;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, registered outputs derived from the next state, and datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      words_left <= 16'd0;
      word_idx   <= '0;
      byte_cnt   <= 2'd0;
      shift      <= 24'd0;
      timer      <= 32'd0;
    end else begin
      state     <= state_n;
      rx_ready  <= (state_n == S_HDR_HI) || (state_n == S_HDR_LO) || (state_n == S_DATA);
      busy      <= (state_n == S_HDR_HI) || (state_n == S_HDR_LO) ||
                   (state_n == S_DATA)   || (state_n == S_WRITE);
      imem_we   <= (state_n == S_WRITE);
      cpu_reset <= (state_n != S_DONE);
      done      <= (state_n == S_DONE);
      error     <= (state_n == S_ERROR);

      if (accept || ((state_n == S_HDR_HI) && (state != S_HDR_HI))) timer <= 32'd0;
      else if (waiting)                                             timer <= timer + 32'd1;

      // A fresh load restarts at word 0 and drops any partial word.
      if ((state_n == S_HDR_HI) && (state != S_HDR_HI)) begin
        byte_cnt <= 2'd0;
        word_idx <= '0;
      end

      case (state)
        S_HDR_HI: if (accept) words_left[15:8] <= rx_data;
        S_HDR_LO: if (accept) words_left[7:0]  <= rx_data;
        S_DATA: begin
          if (accept) begin
            shift    <= {shift[15:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              imem_wdata <= {shift, rx_data};
              imem_addr  <= word_idx;
            end
          end
        end
        S_WRITE: begin
          word_idx   <= word_idx + ONE;
          words_left <= words_left - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: a driver pushes the expected (address, word)
// for every complete word it sends, and a monitor pops and compares each
// write strobe the loader produces.
module tb_imem_boot_loader;

  localparam int AW = 8;
  localparam int TO = 100;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [2:0]    dbg_state;

  imem_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [AW+31:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  int last_accept_cyc = 0;
  logic [31:0] img [0:255];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset_n && imem_we) begin
      logic [AW+31:0] e;
      wr_count++;
      check("rx_ready_low_on_write", {63'd0, rx_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", {24'd0, imem_addr, imem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {56'd0, imem_addr}, {56'd0, e[AW+31:32]});
        check("write_data", {32'd0, imem_wdata}, {32'd0, e[31:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    k = 0;
    while (!rx_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!rx_ready) begin
      check("byte_accept_timeout", 64'd0, 64'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      last_accept_cyc = cyc;
      rx_valid = 1'b0;
    end
  endtask

  // Sends a header for n words then data bytes from img; ndata < 0 sends
  // the full image. Only words sent completely are expected as writes.
  task automatic run_load(input int n, input int ndata, input int gapmax);
    int total;
    logic [7:0] hi, lo;
    hi = n[15:8];
    lo = n[7:0];
    total = (ndata < 0) ? n * 4 : ndata;
    if (n > (1 << AW)) total = 0;
    pulse_start();
    send_byte(hi, $urandom_range(0, gapmax));
    send_byte(lo, $urandom_range(0, gapmax));
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 4; b++) begin
        if (i * 4 + b < total) begin
          if (b == 0 && (i * 4 + 4 <= total)) exp_q.push_back({AW'(i), img[i]});
          send_byte(img[i][31 - 8 * b -: 8], $urandom_range(0, gapmax));
        end
      end
    end
  endtask

  task automatic wait_end(input int budget);
    int k;
    k = 0;
    while (!(done || error) && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (!(done || error)) check("wait_end_timeout", 64'd0, 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_end(input string tag, input logic exp_done, input int exp_writes, input int w0);
    check({tag, "_done"},      {63'd0, done},      {63'd0, exp_done});
    check({tag, "_error"},     {63'd0, error},     {63'd0, !exp_done});
    check({tag, "_cpu_reset"}, {63'd0, cpu_reset}, {63'd0, !exp_done});
    check({tag, "_busy"},      {63'd0, busy},      64'd0);
    check({tag, "_rx_ready"},  {63'd0, rx_ready},  64'd0);
    check({tag, "_writes"},    64'(wr_count - w0), 64'(exp_writes));
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_ready"},   {63'd0, rx_ready},   64'd0);
    check({tag, "_imem_we"},    {63'd0, imem_we},    64'd0);
    check({tag, "_imem_addr"},  {56'd0, imem_addr},  64'd0);
    check({tag, "_imem_wdata"}, {32'd0, imem_wdata}, 64'd0);
    check({tag, "_cpu_reset"},  {63'd0, cpu_reset},  64'd1);
    check({tag, "_busy"},       {63'd0, busy},       64'd0);
    check({tag, "_done"},       {63'd0, done},       64'd0);
    check({tag, "_error"},      {63'd0, error},      64'd0);
    check({tag, "_state_idle"}, {61'd0, dbg_state},  64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w0;
    start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: directed two-word image
    img[0] = 32'h2404_0000;
    img[1] = 32'h8C85_0000;
    w0 = wr_count;
    run_load(2, -1, 0);
    wait_end(50);
    check_end("t1", 1'b1, 2, w0);

    // 2: empty image, done right after the low header byte
    w0 = wr_count;
    run_load(0, -1, 0);
    @(negedge clk);
    check("t2_done_after_lo", {63'd0, done}, 64'd1);
    check("t2_cpu_released",  {63'd0, cpu_reset}, 64'd0);
    wait_end(10);
    check_end("t2", 1'b1, 0, w0);

    // 3: count one beyond capacity rejected, exact capacity accepted
    w0 = wr_count;
    run_load(257, -1, 0);
    wait_end(50);
    check_end("t3_over", 1'b0, 0, w0);
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    w0 = wr_count;
    run_load(256, -1, 0);
    wait_end(50);
    check_end("t3_full", 1'b1, 256, w0);

    // 4: random gaps on rx_valid
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) img[i] = $urandom;
      w0 = wr_count;
      run_load(3, -1, 3);
      wait_end(50);
      check_end("t4", 1'b1, 3, w0);
    end

    // 5: stall after five data bytes, then a clean reload
    img[0] = $urandom; img[1] = $urandom;
    w0 = wr_count;
    run_load(2, 5, 1);
    begin
      int k;
      k = 0;
      while (!error && k < 300) begin
        @(negedge clk);
        k++;
      end
      check("t5_timeout_latency", 64'(cyc - last_accept_cyc), 64'(TO));
    end
    wait_end(10);
    check_end("t5_to", 1'b0, 1, w0);
    w0 = wr_count;
    run_load(2, -1, 2);
    wait_end(50);
    check_end("t5_reload", 1'b1, 2, w0);

    // 6: asynchronous reset in the middle of word 1 of a four-word load
    for (int i = 0; i < 4; i++) img[i] = $urandom;
    run_load(4, 6, 0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_values("t6_async");
    @(negedge clk);
    reset_n = 1'b1;
    check("t6_queue_empty", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 3; i++) img[i] = $urandom;
    w0 = wr_count;
    run_load(3, -1, 2);
    wait_end(50);
    check_end("t6_reload", 1'b1, 3, w0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    check("global_watchdog", 64'd0, 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
